// File: rtl/savestate_sequencer.sv
// Drives the clock divider's halt/turbo/begin_reset controls around a savestate
// transfer, stopping the CPU just after a half (65k-only) tick.
module savestate_sequencer #(
    parameter logic [2:0]  LOAD_TICKS     = 3'd4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ss_save_req,
    input  logic ss_load_req,
    input  logic clk_en_32_768khz,
    input  logic clk_en_65_536khz,
    input  logic ss_xfer_done,
    output logic ss_halt,
    output logic ss_turbo,
    output logic ss_begin_reset,
    output logic ss_xfer_start,
    output logic ss_xfer_is_load,
    output logic ss_busy,
    output logic ss_done,
    output logic ss_error
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_ALIGN,
        LOAD_BEGIN,
        LOAD_COUNT,
        XFER,
        RESUME
    } state_t;

    state_t      state;
    logic        seen_full;
    logic        xfer_issued;
    logic [2:0]  tick_cnt;
    logic [23:0] wait_cnt;

    logic        tick_full;
    logic        tick_half;
    logic        load_reached;
    logic        timed_out;
    logic        waiting;
    logic        advance;
    logic [23:0] wait_inc;

    // A lone 32k strobe is not a legal tick and falls out of both classes.
    assign tick_full    = clk_en_32_768khz & clk_en_65_536khz;
    assign tick_half    = clk_en_65_536khz & ~clk_en_32_768khz;
    assign load_reached = ({1'b0, tick_cnt} + 4'd1) >= {1'b0, LOAD_TICKS};
    assign timed_out    = (wait_cnt == TIMEOUT_CYCLES - 24'd1);
    assign wait_inc     = (wait_cnt == '1) ? wait_cnt : wait_cnt + 24'd1;

    // Progress in a wait state takes priority over a coincident timeout.
    always_comb begin
        advance = 1'b0;
        waiting = 1'b0;
        case (state)
            SAVE_ALIGN: begin
                waiting = 1'b1;
                advance = tick_half & seen_full;
            end
            LOAD_COUNT: begin
                waiting = 1'b1;
                advance = tick_half & load_reached;
            end
            XFER: begin
                waiting = 1'b1;
                advance = xfer_issued & ss_xfer_done;
            end
            default: begin
                advance = 1'b0;
                waiting = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            seen_full       <= 1'b0;
            xfer_issued     <= 1'b0;
            tick_cnt        <= 3'd0;
            wait_cnt        <= 24'd0;
            ss_halt         <= 1'b0;
            ss_turbo        <= 1'b0;
            ss_begin_reset  <= 1'b0;
            ss_xfer_start   <= 1'b0;
            ss_xfer_is_load <= 1'b0;
            ss_busy         <= 1'b0;
            ss_done         <= 1'b0;
            ss_error        <= 1'b0;
        end else begin
            ss_begin_reset <= 1'b0;
            ss_xfer_start  <= 1'b0;
            ss_done        <= 1'b0;
            ss_error       <= 1'b0;

            if (waiting && !advance && timed_out) begin
                state           <= IDLE;
                wait_cnt        <= 24'd0;
                ss_halt         <= 1'b0;
                ss_turbo        <= 1'b0;
                ss_busy         <= 1'b0;
                ss_xfer_is_load <= 1'b0;
                ss_error        <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        wait_cnt <= 24'd0;
                        if (ss_save_req) begin
                            state           <= SAVE_ALIGN;
                            seen_full       <= 1'b0;
                            ss_busy         <= 1'b1;
                            ss_turbo        <= 1'b1;
                            ss_xfer_is_load <= 1'b0;
                        end else if (ss_load_req) begin
                            state           <= LOAD_BEGIN;
                            ss_busy         <= 1'b1;
                            ss_turbo        <= 1'b1;
                            ss_xfer_is_load <= 1'b1;
                            ss_begin_reset  <= 1'b1;
                        end
                    end
                    SAVE_ALIGN: begin
                        if (tick_full) seen_full <= 1'b1;
                        if (advance) begin
                            state       <= XFER;
                            ss_halt     <= 1'b1;
                            xfer_issued <= 1'b0;
                            wait_cnt    <= 24'd0;
                        end else begin
                            wait_cnt <= wait_inc;
                        end
                    end
                    LOAD_BEGIN: begin
                        state    <= LOAD_COUNT;
                        tick_cnt <= 3'd0;
                        wait_cnt <= 24'd0;
                    end
                    LOAD_COUNT: begin
                        // Saturates so a FULL at the target count keeps us armed for the next HALF.
                        if (clk_en_65_536khz && tick_cnt != LOAD_TICKS) tick_cnt <= tick_cnt + 3'd1;
                        if (advance) begin
                            state       <= XFER;
                            ss_halt     <= 1'b1;
                            xfer_issued <= 1'b0;
                            wait_cnt    <= 24'd0;
                        end else begin
                            wait_cnt <= wait_inc;
                        end
                    end
                    XFER: begin
                        if (advance) begin
                            state           <= RESUME;
                            wait_cnt        <= 24'd0;
                            ss_halt         <= 1'b0;
                            ss_turbo        <= 1'b0;
                            ss_busy         <= 1'b0;
                            ss_xfer_is_load <= 1'b0;
                            ss_done         <= 1'b1;
                        end else begin
                            wait_cnt <= wait_inc;
                            if (!xfer_issued) begin
                                ss_xfer_start <= 1'b1;
                                xfer_issued   <= 1'b1;
                            end
                        end
                    end
                    RESUME: begin
                        state    <= IDLE;
                        wait_cnt <= 24'd0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_savestate_sequencer.sv
// Directed bench for savestate_sequencer: an event-level model checked every cycle,
// plus literal expectations taken from the save/load/timeout/reset scenarios.
module tb_savestate_sequencer;

    localparam logic [2:0] LT = 3'd4;
    localparam int         TO = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ss_save_req = 1'b0;
    logic ss_load_req = 1'b0;
    logic clk_en_32_768khz = 1'b0;
    logic clk_en_65_536khz = 1'b0;
    logic ss_xfer_done = 1'b0;
    logic ss_halt, ss_turbo, ss_begin_reset, ss_xfer_start;
    logic ss_xfer_is_load, ss_busy, ss_done, ss_error;

    int checks = 0;
    int errors = 0;

    savestate_sequencer #(
        .LOAD_TICKS(LT),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ss_save_req(ss_save_req),
        .ss_load_req(ss_load_req),
        .clk_en_32_768khz(clk_en_32_768khz),
        .clk_en_65_536khz(clk_en_65_536khz),
        .ss_xfer_done(ss_xfer_done),
        .ss_halt(ss_halt),
        .ss_turbo(ss_turbo),
        .ss_begin_reset(ss_begin_reset),
        .ss_xfer_start(ss_xfer_start),
        .ss_xfer_is_load(ss_xfer_is_load),
        .ss_busy(ss_busy),
        .ss_done(ss_done),
        .ss_error(ss_error)
    );

    always #5 clk = ~clk;

    // Model tracks the sequence as flags: busy, which direction, halted, transfer started.
    bit m_busy, m_load, m_halt, m_turbo, m_start, m_done, m_err, m_breset;
    bit m_seen_full, m_started;
    bit t_full, t_half, t_idle, t_was_breset, t_ok;
    int m_ticks, m_wait;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {m_busy, m_load, m_halt, m_turbo, m_start, m_done, m_err, m_breset} = '0;
            m_seen_full = 0;
            m_started   = 0;
            m_ticks     = 0;
            m_wait      = 0;
        end else begin
            t_full       = clk_en_32_768khz & clk_en_65_536khz;
            t_half       = clk_en_65_536khz & ~clk_en_32_768khz;
            t_idle       = !m_busy && !m_done;
            t_was_breset = m_breset;
            t_ok         = 0;
            m_start = 0; m_done = 0; m_err = 0; m_breset = 0;
            if (t_idle) begin
                if (ss_save_req) begin
                    m_busy = 1; m_turbo = 1; m_load = 0; m_seen_full = 0; m_wait = 0;
                end else if (ss_load_req) begin
                    m_busy = 1; m_turbo = 1; m_load = 1; m_breset = 1; m_ticks = 0; m_wait = 0;
                end
            end else if (m_busy && t_was_breset) begin
                m_wait = 0;
            end else if (m_busy && !m_halt) begin
                if (m_load) begin
                    if (clk_en_65_536khz) m_ticks++;
                    t_ok = t_half && (m_ticks >= int'(LT));
                end else begin
                    t_ok = t_half && m_seen_full;
                    if (t_full) m_seen_full = 1;
                end
                if (t_ok) begin
                    m_halt = 1; m_started = 0; m_wait = 0;
                end else if (m_wait == TO - 1) begin
                    m_busy = 0; m_turbo = 0; m_load = 0; m_err = 1; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else if (m_busy && m_halt) begin
                if (m_started && ss_xfer_done) begin
                    m_busy = 0; m_turbo = 0; m_halt = 0; m_load = 0; m_done = 1; m_wait = 0;
                end else if (m_wait == TO - 1) begin
                    m_busy = 0; m_turbo = 0; m_halt = 0; m_load = 0; m_err = 1; m_wait = 0;
                end else begin
                    m_wait++;
                    if (!m_started) begin
                        m_start = 1; m_started = 1;
                    end
                end
            end
        end
    end

    // Every cycle, mid-period, the full output vector must match the model.
    always @(negedge clk) begin
        checks++;
        if ({ss_halt, ss_turbo, ss_begin_reset, ss_xfer_start, ss_xfer_is_load, ss_busy, ss_done, ss_error} !==
            {m_halt, m_turbo, m_breset, m_start, m_load, m_busy, m_done, m_err}) begin
            errors++;
            $display("[TB] FAIL model_compare t=%0t got h%b t%b br%b st%b ld%b bz%b dn%b er%b expected h%b t%b br%b st%b ld%b bz%b dn%b er%b",
                     $time, ss_halt, ss_turbo, ss_begin_reset, ss_xfer_start, ss_xfer_is_load, ss_busy, ss_done, ss_error,
                     m_halt, m_turbo, m_breset, m_start, m_load, m_busy, m_done, m_err);
        end
    end

    task automatic check_output(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle with the given inputs; returns just after the edge that sampled them.
    task automatic apply_stimulus(input bit s, input bit l, input bit f32, input bit f65, input bit xd);
        ss_save_req      = s;
        ss_load_req      = l;
        clk_en_32_768khz = f32;
        clk_en_65_536khz = f65;
        ss_xfer_done     = xd;
        @(posedge clk);
        #1;
        ss_save_req      = 0;
        ss_load_req      = 0;
        clk_en_32_768khz = 0;
        clk_en_65_536khz = 0;
        ss_xfer_done     = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_halt", ss_halt, 1'b0);
        check_output("reset_turbo", ss_turbo, 1'b0);
        check_output("reset_busy", ss_busy, 1'b0);
        reset_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);

        // Save: request t1, FULL t5, HALF t6, xfer_done t20; stray load_req at t10.
        apply_stimulus(1, 0, 0, 0, 0);
        check_output("save_turbo_t2", ss_turbo, 1'b1);
        check_output("save_busy_t2", ss_busy, 1'b1);
        check_output("save_dir_t2", ss_xfer_is_load, 1'b0);
        repeat (3) apply_stimulus(0, 0, 0, 0, 0);
        check_output("save_nohalt_t5", ss_halt, 1'b0);
        apply_stimulus(0, 0, 1, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("save_halt_t7", ss_halt, 1'b1);
        check_output("save_nostart_t7", ss_xfer_start, 1'b0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("save_start_t8", ss_xfer_start, 1'b1);
        repeat (2) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("save_ignore_load", ss_begin_reset, 1'b0);
        repeat (9) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("save_done_t21", ss_done, 1'b1);
        check_output("save_halt_off_t21", ss_halt, 1'b0);
        check_output("save_turbo_off_t21", ss_turbo, 1'b0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("save_done_pulse", ss_done, 1'b0);

        // Load: ticks F,H,F,H; xfer_done on the same cycle as xfer_start.
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("load_breset", ss_begin_reset, 1'b1);
        check_output("load_dir", ss_xfer_is_load, 1'b1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("load_breset_1cyc", ss_begin_reset, 1'b0);
        apply_stimulus(0, 0, 1, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("load_nohalt_3", ss_halt, 1'b0);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("load_halt_4", ss_halt, 1'b1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("load_start", ss_xfer_start, 1'b1);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("load_done_same_cycle", ss_done, 1'b1);
        apply_stimulus(0, 0, 0, 0, 0);

        // Load where the 4th tick is FULL: halt waits for the following HALF.
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 1, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 1, 1, 0);
        check_output("load_full4_nohalt", ss_halt, 1'b0);
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("load_lone32_ignored", ss_halt, 1'b0);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("load_full4_halt", ss_halt, 1'b1);
        repeat (2) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("load_full4_done", ss_done, 1'b1);
        apply_stimulus(0, 0, 0, 0, 0);

        // Simultaneous requests: save wins; then no xfer_done so XFER times out.
        apply_stimulus(1, 1, 0, 0, 0);
        check_output("both_dir_save", ss_xfer_is_load, 1'b0);
        check_output("both_no_breset", ss_begin_reset, 1'b0);
        check_output("both_turbo", ss_turbo, 1'b1);
        apply_stimulus(0, 0, 1, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("to_halt", ss_halt, 1'b1);
        repeat (99) apply_stimulus(0, 0, 0, 0, 0);
        check_output("to_not_yet", ss_error, 1'b0);
        check_output("to_busy_99", ss_busy, 1'b1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("to_error_100", ss_error, 1'b1);
        check_output("to_halt_off", ss_halt, 1'b0);
        check_output("to_turbo_off", ss_turbo, 1'b0);
        check_output("to_busy_off", ss_busy, 1'b0);
        check_output("to_no_done", ss_done, 1'b0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("to_error_pulse", ss_error, 1'b0);

        // Async reset in LOAD_COUNT, then a fresh save.
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 1, 0);
        check_output("rst_pre_turbo", ss_turbo, 1'b1);
        reset_n = 1'b0;
        #1;
        check_output("rst_turbo", ss_turbo, 1'b0);
        check_output("rst_busy", ss_busy, 1'b0);
        check_output("rst_dir", ss_xfer_is_load, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("post_rst_halt", ss_halt, 1'b1);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("post_rst_start", ss_xfer_start, 1'b1);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("post_rst_done", ss_done, 1'b1);
        repeat (2) apply_stimulus(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
